// File: rtl/fx3_slavefifo_pkg.sv
// Constants shared by the FX3 slave-FIFO reader and its capture path.
package fx3_slavefifo_pkg;

  localparam int unsigned FX3_DATA_W          = 32;
  localparam int unsigned FX3_RD_LATENCY      = 2;
  localparam logic [1:0]  FX3_ADDR_STREAM_OUT = 2'b11;

endpackage

// File: rtl/slavefifo_rx_buf.sv
// Generic first-word-fall-through circular buffer with occupancy and overrun report.
module slavefifo_rx_buf #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [Width-1:0]         rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     full_o,
  output logic                     drop_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  level;
  logic             empty, full, push, pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == PtrW'(Depth));

  assign pop  = rd_en_i & ~empty;
  assign push = wr_en_i & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
  end

  assign rd_data_o  = mem_q[rd_ptr_q[AddrW-1:0]];
  assign rd_valid_o = ~empty;
  assign level_o    = level;
  assign full_o     = full;
  assign drop_o     = wr_en_i & full & ~pop;

endmodule

// File: rtl/slavefifo_stream_out_capture.sv
// FX3 stream-OUT capture: delays SLRD# by the read latency, buffers words, drives hold/overflow.
module slavefifo_stream_out_capture
  import fx3_slavefifo_pkg::*;
#(
  parameter int unsigned DATA_W      = FX3_DATA_W,
  parameter int unsigned RD_LATENCY  = FX3_RD_LATENCY,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HOLD_MARGIN = RD_LATENCY + 2
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic                      slrd_,
  input  logic [DATA_W-1:0]         fdata,
  output logic                      hold,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int unsigned LvlW = $clog2(DEPTH) + 1;
  localparam int unsigned SumW = LvlW + 3;
  localparam logic [SumW-1:0] HoldThresh = SumW'(DEPTH - HOLD_MARGIN);

  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic                  cap_en;
  logic                  hold_q, hold_d;
  logic                  overflow_q, overflow_d;
  logic                  buf_full, buf_drop;
  logic [LvlW-1:0]       buf_level;
  logic [SumW-1:0]       occ_sum;

  always_comb begin
    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = ~slrd_;
  end

  assign cap_en = rd_pipe_q[RD_LATENCY-1];

  slavefifo_rx_buf #(
    .Width (DATA_W),
    .Depth (DEPTH)
  ) u_rx_buf (
    .clk_i      (clk),
    .rst_ni     (reset_),
    .wr_en_i    (cap_en),
    .wr_data_i  (fdata),
    .rd_en_i    (m_ready),
    .rd_data_o  (m_data),
    .rd_valid_o (m_valid),
    .level_o    (buf_level),
    .full_o     (buf_full),
    .drop_o     (buf_drop)
  );

  // Worst-case occupancy: stored words plus every read still in the latency pipe.
  always_comb begin
    occ_sum = SumW'(buf_level) + SumW'(cap_en);
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      occ_sum = occ_sum + SumW'(rd_pipe_q[i]);
    end
    hold_d     = (occ_sum >= HoldThresh);
    overflow_d = overflow_q | buf_drop;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd_pipe_q  <= '0;
      hold_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_pipe_q  <= rd_pipe_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
    end
  end

  assign hold     = hold_q;
  assign overflow = overflow_q;
  assign level    = buf_level;

endmodule

// File: tb/tb_slavefifo_stream_out_capture.sv
// Scoreboard bench: an FX3 read-latency model feeds the DUT and a reference queue.
module tb_slavefifo_stream_out_capture;

  localparam int unsigned DataW      = 32;
  localparam int unsigned RdLat      = 2;
  localparam int unsigned Depth      = 16;
  localparam int unsigned HoldMargin = RdLat + 2;
  localparam int unsigned LvlW       = $clog2(Depth) + 1;

  logic             clk = 1'b0;
  logic             reset_;
  logic             slrd_;
  logic [DataW-1:0] fdata;
  logic             hold;
  logic [DataW-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [LvlW-1:0]  level;
  logic             overflow;

  always #5 clk = ~clk;

  slavefifo_stream_out_capture #(
    .DATA_W      (DataW),
    .RD_LATENCY  (RdLat),
    .DEPTH       (Depth),
    .HOLD_MARGIN (HoldMargin)
  ) dut (
    .clk      (clk),
    .reset_   (reset_),
    .slrd_    (slrd_),
    .fdata    (fdata),
    .hold     (hold),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .level    (level),
    .overflow (overflow)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_popped;

  logic [DataW-1:0] sb_q[$];  // words expected on m_data, in order
  logic [DataW-1:0] fx_q[$];  // words the FX3 owes for issued strobes
  bit [RdLat-1:0]   hist;     // hist[0] = strobe sampled at the previous edge
  int unsigned      mdl_level;
  bit               mdl_ovf;
  logic [DataW-1:0] next_word;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive inputs for the next edge, check, advance the model.
  task automatic tick(input bit rd, input bit rdy);
    bit          cap, pop, acc, hold_exp;
    int unsigned occ;
    cap = hist[RdLat-1];
    slrd_   = ~rd;
    m_ready = rdy;
    if (rd) begin
      fx_q.push_back(next_word);
      next_word = next_word + 1;
    end
    if (cap) fdata = fx_q.pop_front();
    else     fdata = $urandom();
    pop = rdy && (mdl_level != 0);
    check_eq("m_valid", {63'd0, m_valid}, {63'd0, mdl_level != 0});
    check_eq("level", {{(64-LvlW){1'b0}}, level}, 64'(mdl_level));
    if (pop) begin
      if (sb_q.size() == 0) check_eq("sb_underrun", 64'd1, 64'd0);
      else check_eq("m_data", {32'd0, m_data}, {32'd0, sb_q.pop_front()});
      n_popped++;
    end
    occ      = mdl_level + $countones(hist) + (cap ? 1 : 0);
    hold_exp = (occ >= Depth - HoldMargin);
    acc      = cap && ((mdl_level < Depth) || pop);
    @(posedge clk);
    #1;
    if (acc) sb_q.push_back(fdata);
    else if (cap) mdl_ovf = 1'b1;
    mdl_level = mdl_level + (acc ? 1 : 0) - (pop ? 1 : 0);
    hist = {hist[RdLat-2:0], rd};
    check_eq("hold", {63'd0, hold}, {63'd0, hold_exp});
    check_eq("overflow", {63'd0, overflow}, {63'd0, mdl_ovf});
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (mdl_level == 0 && hist == '0) return;
      tick(1'b0, 1'b1);
    end
    check_eq("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    reset_ = 1'b0; slrd_ = 1'b1; m_ready = 1'b0; fdata = '0;
    hist = '0; mdl_level = 0; mdl_ovf = 1'b0; n_popped = 0;
    #23;
    check_eq("rst_hold", {63'd0, hold}, 64'd0);
    check_eq("rst_valid", {63'd0, m_valid}, 64'd0);
    check_eq("rst_level", {{(64-LvlW){1'b0}}, level}, 64'd0);
    check_eq("rst_ovf", {63'd0, overflow}, 64'd0);
    @(posedge clk); #1;
    reset_ = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);

    // Single read
    next_word = 32'hDEADBEEF;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("single_data", {32'd0, m_data}, 64'hDEADBEEF);
    check_eq("single_level", {{(64-LvlW){1'b0}}, level}, 64'd1);
    drain();

    // Burst of 16, consumer stalled
    next_word = 0;
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("burst_level", {{(64-LvlW){1'b0}}, level}, 64'd16);
    check_eq("burst_hold", {63'd0, hold}, 64'd1);
    drain();

    // Fill, then pop in the cycle the 17th word is captured
    next_word = 32'h100;
    for (int i = 0; i < 17; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check_eq("fullpop_level", {{(64-LvlW){1'b0}}, level}, 64'd16);
    check_eq("fullpop_ovf", {63'd0, overflow}, 64'd0);
    drain();

    // Pointer wrap: 100 words, reader honours hold, consumer toggles
    next_word = 32'h1000;
    n_popped = 0;
    begin
      int unsigned left = 100;
      bit rdy = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        if (left == 0 && mdl_level == 0 && hist == '0) break;
        tick((left > 0) && !hold, rdy);
        if (slrd_ == 1'b0) left--;
        rdy = ~rdy;
      end
      check_eq("wrap_left", 64'(left), 64'd0);
    end
    check_eq("wrap_count", 64'(n_popped), 64'd100);
    check_eq("wrap_ovf", {63'd0, overflow}, 64'd0);

    // Overrun: 18 reads ignoring hold
    next_word = 32'h2000;
    for (int i = 0; i < 18; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("ovr_level", {{(64-LvlW){1'b0}}, level}, 64'd16);
    check_eq("ovr_ovf", {63'd0, overflow}, 64'd1);
    check_eq("ovr_head", {32'd0, m_data}, 64'h2000);
    drain();

    // Reset with level 5 and two reads in flight
    next_word = 32'h3000;
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
    check_eq("pre_rst_level", {{(64-LvlW){1'b0}}, level}, 64'd5);
    slrd_ = 1'b1;
    #2;
    reset_ = 1'b0;
    #1;
    check_eq("arst_hold", {63'd0, hold}, 64'd0);
    check_eq("arst_valid", {63'd0, m_valid}, 64'd0);
    check_eq("arst_level", {{(64-LvlW){1'b0}}, level}, 64'd0);
    check_eq("arst_ovf", {63'd0, overflow}, 64'd0);
    sb_q.delete(); fx_q.delete();
    hist = '0; mdl_level = 0; mdl_ovf = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_ = 1'b1;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
    next_word = 32'h4000;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_eq("post_rst_data", {32'd0, m_data}, 64'h4000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/slavefifo_stream_out_capture.md
# slavefifo_stream_out_capture

Downstream capture stage for the FX3 slave-FIFO stream-OUT reader. It watches the active-low read strobe the reader drives to the FX3 and applies the FX3 synchronous read latency. It then samples the 32-bit data bus on the correct edge and buffers each word in a small circular FIFO. Buffered words are presented to the rest of the design as a valid/ready stream, and a registered `hold` tells the reader to stop issuing reads before the buffer can overflow.

## Interface
Parameters:
- `DATA_W`, 32, width of FX3 data bus and output stream
- `RD_LATENCY`, 2, clocks from SLRD# sampled low to valid data on `fdata` (legal 1..4)
- `DEPTH`, 16, buffer entries, power of two, ≥ 8
- `HOLD_MARGIN`, `RD_LATENCY`+2, free entries reserved for in-flight words when `hold` asserts

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  100 MHz interface clock (same clock as the reader's state machine)
- `reset_`  in  1  asynchronous active-low reset
- `slrd_`  in  1  read strobe as driven to FX3, active low
- `fdata`  in  `DATA_W`  FX3 data bus
- `hold`  out  1  registered; reader must not begin or extend a read burst while high
- `m_data`  out  `DATA_W`  head-of-buffer word
- `m_valid`  out  1  buffer non-empty
- `m_ready`  in  1  consumer accepts `m_data` when `m_valid` and `m_ready` are both high
- `level`  out  $clog2(`DEPTH`)+1  current occupancy
- `overflow`  out  1  sticky; set when a word arrives with no room

## Operation
- Strobe pipeline: a `RD_LATENCY`-deep shift register loads `~slrd_` each clock. Its last stage is `cap_en`.
- Capture: when `cap_en`=1, `fdata` is written at `wr_ptr` and `wr_ptr` increments.
- Pop: when `m_valid`&`m_ready`, `rd_ptr` increments.
- Pointers are `$clog2(DEPTH)`+1 bits wide and wrap modulo 2·`DEPTH`. `level` = `wr_ptr`−`rd_ptr`; full is `level`==`DEPTH`.
- Output is first-word-fall-through. `m_data` = mem[`rd_ptr`] (combinational read of registered state). `m_valid` = (`level`≠0).
- Write while full:
  - Accepted if a pop occurs in the same cycle; `level` is unchanged.
  - Otherwise the word is dropped, `overflow` is set, and the pointers are unchanged.
- Simultaneous write and pop with `level`=0: the write is accepted; the pop does not occur (`m_valid`=0).
- `hold` is set next cycle when `level` + (number of ones in the strobe pipeline) + `cap_en` ≥ `DEPTH`−`HOLD_MARGIN`. It is cleared otherwise.
- `overflow` clears only on reset.
- Reset mid-burst:
  - Pipeline, pointers, `hold` and `overflow` all clear.
  - In-flight words are discarded.
  - Buffer memory contents are not reset.

## Timing
- Reset values: `hold`=0, `m_valid`=0, `level`=0, `overflow`=0; `m_data` is don't-care.
- `slrd_` low at edge N → `fdata` sampled at edge N+`RD_LATENCY`.
- That word is visible on `m_data`/`m_valid` immediately after the same edge, if the buffer was empty.
- Back-to-back reads: one word per clock, no bubbles.
- `hold` latency: one clock after the occupancy condition is met.
  - With `HOLD_MARGIN` ≥ `RD_LATENCY`+2, a reader honouring `hold` within one clock never overflows.
- `level` updates on the edge after the write/pop.

## Structure
- Shared package `fx3_slavefifo_pkg`:
  - `FX3_DATA_W`=32
  - `FX3_RD_LATENCY`=2
  - `FX3_ADDR_STREAM_OUT`=2'b11
- Natural sub-module: `slavefifo_rx_buf`, a generic FWFT circular buffer with pointers, `level` and full/empty logic. The top level owns the strobe pipeline, `hold` and `overflow`.

## Test plan
- Single read: `slrd_` low one clock at edge 10 with `fdata`=0xDEADBEEF at edge 12 → `m_valid`=1 and `m_data`=0xDEADBEEF after edge 12; `level`=1.
- Burst of 16 with `m_ready`=0, values 0..15, `DEPTH`=16, `HOLD_MARGIN`=4 → `hold` rises the clock after occupancy plus in-flight reaches 12. Draining then yields 0..15 in order; `overflow`=0.
- Overrun: 18 consecutive reads, `hold` ignored, `m_ready`=0 → `level`=16, `overflow`=1, and the first 16 values are retained.
- Full with simultaneous capture and pop: fill to 16, then assert `m_ready` in the cycle word 17 is captured → `level` stays 16, no overflow, and word 17 is read out last.
- Pointer wrap: stream 100 words with `m_ready` toggling 1/0 → output sequence is identical to input, with no loss or duplication.
- Reset during burst: assert `reset_` low with two words in flight and `level`=5 → all outputs reach reset values asynchronously, and no stale words appear after release.
